uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001: Parameter CLOCKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002: Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003: Parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-004: ipClk  input  1  system clock; all state changes on its rising edge.
REQ-005: ipnReset  input  1  one clock; reset is asynchronous and active-low.
REQ-006: ipTxData  input  8  byte to transmit; sampled only on the acceptance cycle.
REQ-007: ipTxSend  input  1  send request from the host; level-held until opTxBusy is seen high.
REQ-008: opTxBusy  output  1  high from acceptance until the last stop bit completes.
REQ-009: opTx  output  1  serial line; idle high; 8 data bits, LSB first.

Function
REQ-010: States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-011: Acceptance SHALL occur on a rising edge where state=IDLE, ipTxSend=1 and the internal armed flag=1.
REQ-012: On acceptance, ipTxData SHALL be latched into a shift register, armed SHALL clear, and the state SHALL move to START.
REQ-013: On the cycle after acceptance, opTx SHALL be 0 and opTxBusy SHALL be 1; there is exactly one cycle of latency from request to start bit.
REQ-014: armed SHALL set on any cycle where ipTxSend=0, so a held-high ipTxSend never produces a second frame.
REQ-015: Each bit SHALL drive opTx for exactly CLOCKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-016: DATA SHALL emit bit 0 through bit 7 in order, tracked by a 3-bit counter; the transition to the next state occurs when the counter wraps from 7.
REQ-017: Parity bit SHALL be the XOR of the 8 latched bits when PARITY=2, and its inverse when PARITY=1.
REQ-018: STOP SHALL drive opTx=1 for STOP_BITS*CLOCKS_PER_BIT cycles, then return to IDLE.
REQ-019: opTxBusy SHALL fall on the same edge that enters IDLE; total busy time SHALL equal (10 + (PARITY!=0) + STOP_BITS - 1) * CLOCKS_PER_BIT cycles.
REQ-020: Acceptance SHALL be possible on the edge immediately after IDLE is entered (back-to-back frames, no idle gap) if ipTxSend=1 and armed=1.
REQ-021: Changes on ipTxData or ipTxSend during a frame SHALL NOT alter the frame in progress.
REQ-022: opTx and opTxBusy SHALL be registered outputs, with no combinational path from any input.
REQ-023: In IDLE, opTx SHALL be 1.

Reset
REQ-024: While ipnReset=0: opTx=1, opTxBusy=0, state=IDLE, armed=0, counters=0, shift register=0; this takes effect immediately and does not wait for a clock edge.
REQ-025: Reset mid-frame SHALL abort the frame; the line SHALL return high at once, and no partial frame SHALL resume after release.
REQ-026: After release, ipTxSend SHALL be seen low at least once before the first acceptance (armed starts clear).

Verification (CLOCKS_PER_BIT=4 unless stated)
REQ-027: Idle; release reset, ipTxSend=0 then pulse high with ipTxData=8'h55 until Busy -> opTx sequence 0,1,0,1,0,1,0,1,0,1, each 4 cycles; Busy high 40 cycles.
REQ-028: Hold ipTxSend=1 for 200 cycles, ipTxData=8'hA3 -> exactly one frame; no second start bit.
REQ-029: PARITY=2 with 8'h07, then PARITY=1 with 8'h07 -> parity bits 1 and 0 respectively; busy 44 cycles; STOP_BITS=2 adds 4 further high cycles.
REQ-030: Drop ipTxSend after Busy; re-raise it 1 cycle before Busy falls with 8'h0D -> second start bit on the cycle after IDLE is entered; no gap.
REQ-031: Assert ipnReset=0 asynchronously mid-DATA -> opTx=1 and opTxBusy=0 before the next clock edge; after release with ipTxSend held high, no frame until ipTxSend toggles low then high.
REQ-032: Change ipTxData from 8'hF0 to 8'h0F one cycle after acceptance -> transmitted bits match 8'hF0.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter with optional parity and
// one or two stop bits. Frames start on a level-held send request that must
// be seen low between frames; opTx and opTxBusy come straight from flops.
module uart_tx #(
    parameter int unsigned CLOCKS_PER_BIT = 434,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic       ipClk,
    input  logic       ipnReset,
    input  logic [7:0] ipTxData,
    input  logic       ipTxSend,
    output logic       opTxBusy,
    output logic       opTx
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST  = 16'(CLOCKS_PER_BIT - 32'd1);
    localparam logic        HAS_PARITY = (PARITY != 32'd0);
    localparam logic        PAR_ODD    = (PARITY == 32'd1);
    localparam logic        STOP_LAST  = (STOP_BITS == 32'd2);

    // Even parity is the XOR of the byte; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t      state_q,    state_d;
    logic [15:0] baud_q,     baud_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic        armed_q,    armed_d;
    logic        tx_q,       tx_d;
    logic        busy_q,     busy_d;

    logic        baud_last_s;
    logic [2:0]  next_bit_s;

    assign baud_last_s = (baud_q == BAUD_LAST);
    assign next_bit_s  = bit_cnt_q + 3'd1;
    assign opTx        = tx_q;
    assign opTxBusy    = busy_q;

    // State and datapath registers; reset drives the line high immediately.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state_q    <= ST_IDLE;
            baud_q     <= 16'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'd0;
            armed_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            armed_q    <= armed_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: bit sequencing, baud timing and next output values.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        // A low request re-arms; a held-high request cannot start a second frame.
        if (!ipTxSend) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        case (state_q)
            ST_IDLE: begin
                baud_d = 16'd0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (ipTxSend && armed_q) begin
                    shift_d    = ipTxData;
                    armed_d    = 1'b0;
                    state_d    = ST_START;
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d    = 16'd0;
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d    = 16'd0;
                    bit_cnt_d = next_bit_s;
                    if (bit_cnt_q == 3'd7) begin
                        if (HAS_PARITY) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit(shift_q, PAR_ODD);
                        end else begin
                            state_d    = ST_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_d = shift_q[next_bit_s];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d     = 16'd0;
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_last_s) begin
                    baud_d = 16'd0;
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = 16'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at 4 clocks per bit. Four instances
// cover no parity, even parity, odd parity and even parity with two stops.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] send_v;
    logic [7:0] data_v [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;

    int n_checks;
    int n_errors;

    uart_tx #(.CLOCKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .ipClk(clk), .ipnReset(rst_n), .ipTxData(data_v[0]), .ipTxSend(send_v[0]),
        .opTxBusy(busy_w[0]), .opTx(tx_w[0]));
    uart_tx #(.CLOCKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut_even (
        .ipClk(clk), .ipnReset(rst_n), .ipTxData(data_v[1]), .ipTxSend(send_v[1]),
        .opTxBusy(busy_w[1]), .opTx(tx_w[1]));
    uart_tx #(.CLOCKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut_odd (
        .ipClk(clk), .ipnReset(rst_n), .ipTxData(data_v[2]), .ipTxSend(send_v[2]),
        .opTxBusy(busy_w[2]), .opTx(tx_w[2]));
    uart_tx #(.CLOCKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut_stop2 (
        .ipClk(clk), .ipnReset(rst_n), .ipTxData(data_v[3]), .ipTxSend(send_v[3]),
        .opTxBusy(busy_w[3]), .opTx(tx_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a frame on instance sel, records it cycle by cycle and checks it
    // against the hand-given byte, parity bit (-1 = none) and busy length.
    task automatic run_frame(input int sel, input logic [7:0] exp_data, input int exp_par,
                             input int exp_busy, input string tag,
                             input int drop_at, input int raise_at, input logic [7:0] raise_data,
                             input int chg_at, input logic [7:0] chg_data, output int gap);
        logic       line [64];
        logic [7:0] rx;
        logic       expb;
        int         w, n, k, mism;
        w = 0;
        forever begin
            @(negedge clk);
            if (busy_w[sel]) break;
            w++;
            if (w >= 40) break;
        end
        gap = w;
        if (!busy_w[sel]) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        n = 0;
        while (busy_w[sel] && n < 64) begin
            line[n] = tx_w[sel];
            if (n == drop_at) send_v[sel] = 1'b0;
            if (n == raise_at) begin
                send_v[sel] = 1'b1;
                data_v[sel] = raise_data;
            end
            if (n == chg_at) data_v[sel] = chg_data;
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, n, exp_busy);
        check({tag, "_idle_high"}, {31'd0, tx_w[sel]}, 32'd1);
        mism = 0;
        for (int i = 0; i < n; i++) begin
            k = i / CPB;
            if (k == 0) expb = 1'b0;
            else if (k <= 8) expb = exp_data[k-1];
            else if (k == 9 && exp_par >= 0) expb = exp_par[0];
            else expb = 1'b1;
            if (line[i] !== expb) mism++;
        end
        check({tag, "_bit_errors"}, mism, 32'd0);
        for (int b = 0; b < 8; b++) begin
            if ((b + 1) * CPB + 2 < n) rx[b] = line[(b + 1) * CPB + 2];
            else rx[b] = 1'bx;
        end
        check({tag, "_data"}, {24'd0, rx}, {24'd0, exp_data});
    endtask

    initial begin
        int gap;
        int cnt;
        n_checks = 0;
        n_errors = 0;
        send_v = 4'b0000;
        for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {28'd0, tx_w}, 32'hF);
        check("reset_busy", {28'd0, busy_w}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0x55, request held until busy.
        data_v[0] = 8'h55;
        send_v[0] = 1'b1;
        run_frame(0, 8'h55, -1, 40, "f55", 0, -1, 8'h00, -1, 8'h00, gap);
        check("f55_latency", gap, 32'd0);
        repeat (2) @(negedge clk);

        // Request held high for about 200 cycles: one frame only.
        data_v[0] = 8'hA3;
        send_v[0] = 1'b1;
        run_frame(0, 8'hA3, -1, 40, "fa3", -1, -1, 8'h00, -1, 8'h00, gap);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy_w[0]) cnt++;
        end
        check("fa3_no_second", cnt, 32'd0);
        send_v[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Parity variants with 0x07.
        data_v[1] = 8'h07;
        send_v[1] = 1'b1;
        run_frame(1, 8'h07, 1, 44, "even07", 0, -1, 8'h00, -1, 8'h00, gap);
        data_v[2] = 8'h07;
        send_v[2] = 1'b1;
        run_frame(2, 8'h07, 0, 44, "odd07", 0, -1, 8'h00, -1, 8'h00, gap);
        data_v[3] = 8'h07;
        send_v[3] = 1'b1;
        run_frame(3, 8'h07, 1, 48, "even07_2stop", 0, -1, 8'h00, -1, 8'h00, gap);
        repeat (2) @(negedge clk);

        // Back-to-back: re-raise on the last busy cycle with 0x0D.
        data_v[0] = 8'h3C;
        send_v[0] = 1'b1;
        run_frame(0, 8'h3C, -1, 40, "b2b_first", 0, 39, 8'h0D, -1, 8'h00, gap);
        run_frame(0, 8'h0D, -1, 40, "b2b_second", 0, -1, 8'h00, -1, 8'h00, gap);
        check("b2b_gap", gap, 32'd0);
        repeat (2) @(negedge clk);

        // Data changes one cycle after acceptance must not reach the line.
        data_v[0] = 8'hF0;
        send_v[0] = 1'b1;
        run_frame(0, 8'hF0, -1, 40, "ff0_hold", 0, -1, 8'h00, 0, 8'h0F, gap);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of the data bits.
        data_v[0] = 8'h00;
        send_v[0] = 1'b1;
        cnt = 0;
        while (!busy_w[0] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_mid_started", {31'd0, busy_w[0]}, 32'd1);
        repeat (12) @(negedge clk);
        check("rst_mid_line_low", {31'd0, tx_w[0]}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", {31'd0, tx_w[0]}, 32'd1);
        check("rst_mid_busy", {31'd0, busy_w[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_w[0] || !tx_w[0]) cnt++;
        end
        check("rst_no_resume", cnt, 32'd0);
        send_v[0] = 1'b0;
        @(negedge clk);
        data_v[0] = 8'h96;
        send_v[0] = 1'b1;
        run_frame(0, 8'h96, -1, 40, "after_rst", 0, -1, 8'h00, -1, 8'h00, gap);
        check("after_rst_latency", gap, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
